// File: rtl/axi_cmd_controller.sv
// Host command sequencer for the regex core: decodes register commands, shares the
// code/string BRAM between host and core, and runs the match session and watchdog.
module axi_cmd_controller #(
   parameter int REG_WIDTH  = 40,
   parameter int ADDR_WIDTH = 12,
   parameter int TIMEOUT_CC = 1048576
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_WIDTH-1:0]  cmd_register,
   input  logic [REG_WIDTH-1:0]  address_register,
   input  logic [REG_WIDTH-1:0]  data_in_register,
   input  logic [REG_WIDTH-1:0]  start_cc_pointer_register,
   input  logic [REG_WIDTH-1:0]  end_cc_pointer_register,
   output logic [REG_WIDTH-1:0]  status_register,
   output logic [REG_WIDTH-1:0]  data_o_register,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [REG_WIDTH-1:0]  mem_wdata,
   input  logic [REG_WIDTH-1:0]  mem_rdata,
   output logic                  core_start,
   output logic                  core_rst,
   output logic [REG_WIDTH-1:0]  core_start_ptr,
   output logic [REG_WIDTH-1:0]  core_end_ptr,
   input  logic                  core_mem_en,
   input  logic [ADDR_WIDTH-1:0] core_mem_addr,
   input  logic                  core_done,
   input  logic                  core_accept
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUNNING  = 3'd1,
      ST_ACCEPTED = 3'd2,
      ST_REJECTED = 3'd3,
      ST_ERROR    = 3'd4
   } status_t;

   localparam logic [REG_WIDTH-1:0] CMD_WRITE   = REG_WIDTH'(1);
   localparam logic [REG_WIDTH-1:0] CMD_READ    = REG_WIDTH'(2);
   localparam logic [REG_WIDTH-1:0] CMD_START   = REG_WIDTH'(3);
   localparam logic [REG_WIDTH-1:0] CMD_RESET   = REG_WIDTH'(4);
   localparam logic [REG_WIDTH-1:0] CMD_ELAPSED = REG_WIDTH'(5);
   localparam logic [REG_WIDTH-1:0] TO_LAST =
      (TIMEOUT_CC == 0) ? '0 : REG_WIDTH'(TIMEOUT_CC - 1);

   state_t                 state_q, state_d;
   status_t                status_q, status_d;
   logic [REG_WIDTH-1:0]   cnt_q, cnt_d;
   logic [REG_WIDTH-1:0]   dout_q, dout_d;
   logic [REG_WIDTH-1:0]   sptr_q, sptr_d;
   logic [REG_WIDTH-1:0]   eptr_q, eptr_d;
   logic                   rd_pend_q, rd_pend_d;
   logic                   start_q, start_d;
   logic                   crst_q, crst_d;

   logic cmd_write, cmd_read, cmd_start, cmd_reset, cmd_elapsed;
   logic unused_addr_hi;

   assign cmd_write   = (cmd_register == CMD_WRITE);
   assign cmd_read    = (cmd_register == CMD_READ);
   assign cmd_start   = (cmd_register == CMD_START);
   assign cmd_reset   = (cmd_register == CMD_RESET);
   assign cmd_elapsed = (cmd_register == CMD_ELAPSED);

   assign unused_addr_hi = ^address_register[REG_WIDTH-1:ADDR_WIDTH];

   // BRAM belongs to the core only while a session is running
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = address_register[ADDR_WIDTH-1:0];
      mem_wdata = data_in_register;
      if (state_q == S_RUN) begin
         mem_en   = core_mem_en;
         mem_addr = core_mem_addr;
      end else begin
         mem_we = cmd_write;
         mem_en = cmd_write | cmd_read;
      end
   end

   always_comb begin
      state_d   = state_q;
      status_d  = status_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      sptr_d    = sptr_q;
      eptr_d    = eptr_q;
      rd_pend_d = cmd_read && (state_q != S_RUN);
      start_d   = 1'b0;
      crst_d    = 1'b0;

      if (rd_pend_q)
         dout_d = mem_rdata;
      // elapsed readout takes priority over a read landing in the same cycle
      if (cmd_elapsed)
         dout_d = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_start) begin
               state_d  = S_RUN;
               status_d = ST_RUNNING;
               cnt_d    = '0;
               sptr_d   = start_cc_pointer_register;
               eptr_d   = end_cc_pointer_register;
               start_d  = 1'b1;
            end
         end
         S_RUN: begin
            if (core_done) begin
               state_d  = S_DONE;
               status_d = core_accept ? ST_ACCEPTED : ST_REJECTED;
            end else if ((TIMEOUT_CC != 0) && (cnt_q == TO_LAST)) begin
               state_d  = S_DONE;
               status_d = ST_ERROR;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + REG_WIDTH'(1);
            end
         end
         S_DONE:  ;
         default: state_d = S_IDLE;
      endcase

      // host abort wins over anything the session did this cycle
      if (cmd_reset) begin
         state_d  = S_IDLE;
         status_d = ST_IDLE;
         cnt_d    = '0;
         start_d  = 1'b0;
         crst_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         status_q  <= ST_IDLE;
         cnt_q     <= '0;
         dout_q    <= '0;
         sptr_q    <= '0;
         eptr_q    <= '0;
         rd_pend_q <= 1'b0;
         start_q   <= 1'b0;
         crst_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         status_q  <= status_d;
         cnt_q     <= cnt_d;
         dout_q    <= dout_d;
         sptr_q    <= sptr_d;
         eptr_q    <= eptr_d;
         rd_pend_q <= rd_pend_d;
         start_q   <= start_d;
         crst_q    <= crst_d;
      end
   end

   assign status_register = {{(REG_WIDTH-3){1'b0}}, status_q};
   assign data_o_register = dout_q;
   assign core_start      = start_q;
   assign core_rst        = crst_q;
   assign core_start_ptr  = sptr_q;
   assign core_end_ptr    = eptr_q;

endmodule

// File: tb/tb_axi_cmd_controller.sv
// Scoreboard bench for axi_cmd_controller: a long-watchdog instance plus a TIMEOUT_CC=8
// instance share host/core stimulus; a negedge monitor checks timed and pulse expectations.
module tb_axi_cmd_controller;
   localparam int RW = 40;
   localparam int AW = 12;
   localparam logic [RW-1:0] C_NOP = 0, C_WR = 1, C_RD = 2, C_START = 3, C_RESET = 4, C_ELAP = 5;
   localparam logic [RW-1:0] ST_IDLE = 0, ST_RUN = 1, ST_ACC = 2, ST_REJ = 3, ST_ERR = 4;
   localparam int S_STATUS = 0, S_DOUT = 1, S_CRST = 2, S_STAT8 = 3;

   typedef struct {
      int            at;
      int            sel;
      logic [RW-1:0] val;
      string         name;
   } exp_t;
   typedef struct {
      logic [RW-1:0] s;
      logic [RW-1:0] e;
   } start_t;

   logic clk = 1'b0;
   logic rst;
   logic [RW-1:0] cmd, addr, wdata, sptr, eptr;
   logic [RW-1:0] status, dout, mem_wdata, mem_rdata, cs_ptr, ce_ptr;
   logic          mem_en, mem_we, core_start, core_rst;
   logic [AW-1:0] mem_addr, core_mem_addr;
   logic          core_mem_en, core_done, core_accept;

   logic [RW-1:0] d8_status, d8_dout, d8_wdata, d8_sptr, d8_eptr;
   logic          d8_en, d8_we, d8_start, d8_crst;
   logic [AW-1:0] d8_addr;
   logic          unused_d8;
   assign unused_d8 = ^{d8_dout, d8_wdata, d8_sptr, d8_eptr, d8_en, d8_we, d8_start, d8_crst, d8_addr};

   int     cyc = 0;
   int     errors = 0;
   int     checks = 0;
   exp_t   sbq[$];
   start_t sq[$];
   logic [RW-1:0] bram [0:(1<<AW)-1];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) bram[mem_addr] <= mem_wdata;
         mem_rdata <= bram[mem_addr];
      end
   end

   axi_cmd_controller #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .TIMEOUT_CC(1000)) dut (
      .clk(clk), .rst(rst), .cmd_register(cmd), .address_register(addr),
      .data_in_register(wdata), .start_cc_pointer_register(sptr),
      .end_cc_pointer_register(eptr), .status_register(status), .data_o_register(dout),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .core_start(core_start), .core_rst(core_rst),
      .core_start_ptr(cs_ptr), .core_end_ptr(ce_ptr), .core_mem_en(core_mem_en),
      .core_mem_addr(core_mem_addr), .core_done(core_done), .core_accept(core_accept));

   axi_cmd_controller #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .TIMEOUT_CC(8)) dut8 (
      .clk(clk), .rst(rst), .cmd_register(cmd), .address_register(addr),
      .data_in_register(wdata), .start_cc_pointer_register(sptr),
      .end_cc_pointer_register(eptr), .status_register(d8_status), .data_o_register(d8_dout),
      .mem_en(d8_en), .mem_we(d8_we), .mem_addr(d8_addr), .mem_wdata(d8_wdata),
      .mem_rdata(mem_rdata), .core_start(d8_start), .core_rst(d8_crst),
      .core_start_ptr(d8_sptr), .core_end_ptr(d8_eptr), .core_mem_en(core_mem_en),
      .core_mem_addr(core_mem_addr), .core_done(core_done), .core_accept(core_accept));

   function automatic logic [RW-1:0] obs(input int sel);
      case (sel)
         S_STATUS: return status;
         S_DOUT:   return dout;
         S_CRST:   return {{(RW-1){1'b0}}, core_rst};
         default:  return d8_status;
      endcase
   endfunction

   // monitor: timed expectations plus one queued pointer pair per core_start pulse
   always @(negedge clk) begin
      logic [RW-1:0] act;
      start_t        st;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].at <= cyc) begin
            act = obs(sbq[i].sel);
            checks++;
            if (sbq[i].at != cyc || act !== sbq[i].val) begin
               errors++;
               $display("FAIL %s @cyc %0d: got %0h, want %0h", sbq[i].name, cyc, act, sbq[i].val);
            end
            sbq.delete(i);
         end
      end
      if (core_start === 1'b1) begin
         checks++;
         if (sq.size() == 0) begin
            errors++;
            $display("FAIL unexpected core_start @cyc %0d: got 1, want 0", cyc);
         end else begin
            st = sq.pop_front();
            if (cs_ptr !== st.s || ce_ptr !== st.e) begin
               errors++;
               $display("FAIL core ptrs @cyc %0d: got %0d/%0d, want %0d/%0d",
                        cyc, cs_ptr, ce_ptr, st.s, st.e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [RW-1:0] c, input logic [RW-1:0] a, input logic [RW-1:0] d);
      cmd = c; addr = a; wdata = d;
   endtask

   task automatic exp_at(input int d, input int sel, input logic [RW-1:0] v, input string n);
      exp_t e;
      e.at = cyc + d; e.sel = sel; e.val = v; e.name = n;
      sbq.push_back(e);
   endtask

   task automatic exp_start(input logic [RW-1:0] s, input logic [RW-1:0] e);
      start_t t;
      t.s = s; t.e = e;
      sq.push_back(t);
   endtask

   task automatic host_reset();
      drive(C_RESET, 0, 0); tick;
      drive(C_NOP, 0, 0);   tick;
   endtask

   initial begin
      rst = 1'b1; drive(C_NOP, 0, 0); sptr = 0; eptr = 0;
      core_mem_en = 1'b0; core_mem_addr = '0; core_done = 1'b0; core_accept = 1'b0;

      // power-on reset
      exp_at(1, S_STATUS, ST_IDLE, "rst status");
      exp_at(1, S_DOUT, 0, "rst dout");
      exp_at(1, S_CRST, 1, "rst core_rst");
      tick;
      rst = 1'b0;
      exp_at(1, S_CRST, 0, "core_rst one cycle");
      tick;

      // single write / read-back
      drive(C_WR, 3, 40'h12345_6789A); tick;
      drive(C_RD, 3, 0); exp_at(2, S_DOUT, 40'h12345_6789A, "rd addr3"); tick;
      drive(C_NOP, 0, 0); tick; tick;

      // burst write then streaming read
      for (int a = 0; a < 8; a++) begin
         drive(C_WR, RW'(a), RW'(a * 5)); tick;
      end
      for (int a = 0; a < 8; a++) begin
         drive(C_RD, RW'(a), 0); exp_at(2, S_DOUT, RW'(a * 5), $sformatf("burst rd %0d", a)); tick;
      end
      drive(C_NOP, 0, 0); tick; tick;

      // accepted session of 25 counted cycles
      sptr = 16; eptr = 40;
      drive(C_START, 0, 0); exp_start(16, 40); exp_at(1, S_STATUS, ST_RUN, "status running"); tick;
      drive(C_NOP, 0, 0); exp_at(12, S_STATUS, ST_RUN, "running mid session");
      repeat (25) tick;
      core_done = 1'b1; core_accept = 1'b1; exp_at(1, S_STATUS, ST_ACC, "accepted"); tick;
      core_done = 1'b0; core_accept = 1'b0;
      drive(C_ELAP, 0, 0); exp_at(1, S_DOUT, 25, "elapsed 25"); tick;
      drive(C_NOP, 0, 0); tick;

      // host traffic during RUN is ignored, result rejected
      drive(C_RESET, 0, 0);
      exp_at(1, S_STATUS, ST_IDLE, "reset cmd status");
      exp_at(1, S_CRST, 1, "reset cmd core_rst");
      exp_at(1, S_DOUT, 25, "reset keeps dout");
      tick;
      drive(C_NOP, 0, 0); exp_at(1, S_CRST, 0, "reset cmd core_rst one cycle"); tick;
      sptr = 7; eptr = 9;
      drive(C_START, 0, 0); exp_start(7, 9); tick;
      tick;
      drive(C_WR, 3, 40'hDEAD); tick;
      drive(C_START, 0, 0);     tick;
      drive(C_WR, 3, 40'hBEEF); tick;
      drive(C_START, 0, 0);     tick;
      drive(C_NOP, 0, 0); core_done = 1'b1; core_accept = 1'b0;
      exp_at(1, S_STATUS, ST_REJ, "rejected"); tick;
      core_done = 1'b0;
      drive(C_START, 0, 0); exp_at(1, S_STATUS, ST_REJ, "start in done ignored"); tick;
      drive(C_RD, 3, 0); exp_at(2, S_DOUT, 15, "addr3 untouched in run"); tick;
      drive(C_NOP, 0, 0); tick;

      // watchdog expiry on the TIMEOUT_CC=8 instance
      host_reset();
      drive(C_START, 0, 0); exp_start(7, 9); exp_at(1, S_STAT8, ST_RUN, "t8 running"); tick;
      drive(C_NOP, 0, 0);
      exp_at(7, S_STAT8, ST_RUN, "t8 running at limit-1");
      exp_at(8, S_STAT8, ST_ERR, "t8 timeout error");
      exp_at(8, S_STATUS, ST_RUN, "long watchdog still running");
      repeat (9) tick;

      // core_done on the timeout cycle wins
      host_reset();
      drive(C_START, 0, 0); exp_start(7, 9); tick;
      drive(C_NOP, 0, 0); repeat (7) tick;
      core_done = 1'b1; core_accept = 1'b1;
      exp_at(1, S_STAT8, ST_ACC, "done beats timeout");
      exp_at(1, S_STATUS, ST_ACC, "accepted before limit");
      tick;
      core_done = 1'b0; core_accept = 1'b0;

      // abort mid-RUN, late done ignored
      host_reset();
      drive(C_START, 0, 0); exp_start(7, 9); tick;
      drive(C_NOP, 0, 0); repeat (3) tick;
      drive(C_RESET, 0, 0);
      exp_at(1, S_STATUS, ST_IDLE, "abort status");
      exp_at(1, S_CRST, 1, "abort core_rst");
      exp_at(1, S_DOUT, 15, "abort keeps dout");
      tick;
      drive(C_NOP, 0, 0); core_done = 1'b1; core_accept = 1'b1;
      exp_at(1, S_STATUS, ST_IDLE, "late done ignored"); tick;
      core_done = 1'b0; core_accept = 1'b0;
      exp_at(1, S_STATUS, ST_IDLE, "stays idle"); tick;
      drive(C_ELAP, 0, 0); exp_at(1, S_DOUT, 0, "elapsed cleared by reset"); tick;

      // rst while a read is pending
      drive(C_RD, 2, 0); exp_at(2, S_DOUT, 10, "rd addr2"); tick;
      drive(C_RD, 1, 0); tick;
      rst = 1'b1; drive(C_NOP, 0, 0);
      exp_at(1, S_DOUT, 0, "rst clears dout");
      exp_at(1, S_STATUS, ST_IDLE, "rst status again");
      tick;
      rst = 1'b0; exp_at(1, S_DOUT, 0, "pending read dropped by rst"); tick;
      repeat (3) tick;

      checks++;
      if (sq.size() != 0) begin
         errors++;
         $display("FAIL core_start count: got %0d missing pulses, want 0", sq.size());
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending, want 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/axi_cmd_controller.md
Name: axi_cmd_controller

Overview:
- Command sequencer between the host register file (`cmd_register` / `status_register` / `data_o_register`) and the regex-matching core plus its shared code/string BRAM.
- Decodes host commands (WRITE, READ, START, RESET, READ_ELAPSED_CLOCK).
- Arbitrates the single BRAM port between the host and the core.
- Runs the match-session state machine, the elapsed-clock counter and the watchdog.

Parameters:
- REG_WIDTH, 40, width of host data/address/pointer registers
- ADDR_WIDTH, 12, BRAM word-address width
- TIMEOUT_CC, 1048576, watchdog limit in RUN cycles; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_register  in  REG_WIDTH  host command. NOP=0, WRITE=1, READ=2, START=3, RESET=4, READ_ELAPSED_CLOCK=5; other values behave as NOP
- address_register  in  REG_WIDTH  host BRAM word address; low ADDR_WIDTH bits used
- data_in_register  in  REG_WIDTH  host write data
- start_cc_pointer_register  in  REG_WIDTH  string start byte pointer for the core
- end_cc_pointer_register  in  REG_WIDTH  string end byte pointer for the core
- status_register  out  REG_WIDTH  status. IDLE=0, RUNNING=1, ACCEPTED=2, REJECTED=3, ERROR=4
- data_o_register  out  REG_WIDTH  read-back data
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_WIDTH  BRAM address
- mem_wdata  out  REG_WIDTH  BRAM write data
- mem_rdata  in  REG_WIDTH  BRAM read data, valid one cycle after mem_en
- core_start  out  1  one-cycle start pulse to the core
- core_rst  out  1  one-cycle synchronous reset pulse to the core
- core_start_ptr  out  REG_WIDTH  latched start pointer
- core_end_ptr  out  REG_WIDTH  latched end pointer
- core_mem_en  in  1  core BRAM read request
- core_mem_addr  in  ADDR_WIDTH  core BRAM read address
- core_done  in  1  core finished (single-cycle or level)
- core_accept  in  1  match result, sampled when core_done=1

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; status=IDLE; data_o_register=0; cc_counter=0.
  - core_start=0, core_rst=1 for that cycle only; core pointers=0.
  - rst has priority over every command, including mid-RUN.
- States: IDLE, RUN, DONE. All state and command decoding happens on posedge clk.
- BRAM mux (combinational, selected by state):
  - RUN: mem_en=core_mem_en, mem_addr=core_mem_addr, mem_we=0.
  - Otherwise: mem_addr=address_register[ADDR_WIDTH-1:0]; mem_wdata=data_in_register; mem_we=(cmd==WRITE); mem_en=(cmd==WRITE or cmd==READ).
  - Host WRITE/READ issued while in RUN is ignored; no write ever reaches the BRAM in RUN.
- WRITE: one word is written every cycle the command is held. The host may change address/data each cycle with cmd held at WRITE (burst).
- READ:
  - A one-deep pending flag is set on each READ cycle outside RUN.
  - On the next edge, data_o_register <= mem_rdata.
  - Latency: READ sampled at edge k, data_o_register valid after edge k+1.
  - Holding READ streams data with the same 2-edge latency per address.
- START:
  - Accepted in IDLE only; ignored in RUN and DONE.
  - On acceptance: latch both pointers into core_start_ptr/core_end_ptr, assert core_start for exactly 1 cycle, clear cc_counter, go to RUN.
  - status=RUNNING after the accepting edge.
  - Holding START does not re-trigger; a new START requires passing through IDLE.
- RUN:
  - cc_counter increments each cycle, saturating at all-ones.
  - core_done=1: go to DONE; status=ACCEPTED if core_accept else REJECTED; counter freezes (the done cycle is not counted).
  - If TIMEOUT_CC≠0 and cc_counter reaches TIMEOUT_CC-1 without core_done: go to DONE, status=ERROR.
  - core_done and timeout in the same cycle: core_done wins.
- DONE: status held; the BRAM returns to the host.
- READ_ELAPSED_CLOCK: data_o_register <= zero-extended cc_counter on the sampling edge; valid in any state. A concurrent pending READ result is overwritten by this.
- RESET command:
  - From any state: state=IDLE, status=IDLE, cc_counter=0.
  - core_rst pulses for 1 cycle; data_o_register is retained.
  - Mid-RUN it aborts the session; a late core_done afterwards is ignored.
- core_done in IDLE or DONE is ignored.

Test Plan:
- After rst: status=0, data_o=0, core_rst high 1 cycle. WRITE addr 3 data 40'h12345_6789A, then READ addr 3 -> data_o_register=40'h12345_6789A two edges after READ.
- Burst: cmd held WRITE over addresses 0..7 with data=addr*5, then held READ 0..7 -> each value appears 2 edges after its address; no missed or duplicate writes.
- START with pointers 16/40, core asserts core_done+core_accept after 25 cycles -> core_start 1-cycle pulse, core_start_ptr=16, status RUNNING then ACCEPTED, READ_ELAPSED_CLOCK returns 25.
- During RUN, host WRITE to addr 3 plus repeated START -> BRAM addr 3 unchanged, no second core_start. core_done with core_accept=0 -> status=REJECTED.
- TIMEOUT_CC=8, core never done -> status=ERROR after 8 RUN cycles. Same-cycle core_done+timeout -> ACCEPTED/REJECTED, not ERROR.
- RESET command mid-RUN, then core_done -> status IDLE and stays IDLE. rst asserted during READ pending -> data_o_register=0.
